// File: rtl/bin2gray_ptr.sv
// Registered binary/Gray pointer for async FIFO write and read pointers.
// The Gray bus comes straight from a flop so it can feed a synchronizer in another domain.
module bin2gray_ptr #(
   parameter int unsigned SIZE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            clr,
   output logic [SIZE-1:0] bin,
   output logic [SIZE-1:0] gray,
   output logic [SIZE-1:0] bin_next,
   output logic [SIZE-1:0] gray_next,
   output logic            wrap
);

   logic wrap_next;

   always_comb begin
      bin_next = bin;
      if (clr) begin
         bin_next = '0;
      end else if (inc) begin
         bin_next = bin + SIZE'(1);
      end
   end

   // Gray is encoded from bin_next so the registered gray never passes through logic.
   assign gray_next = (bin_next >> 1) ^ bin_next;

   // Only an increment out of all-ones counts as a rollover; clr never does.
   assign wrap_next = inc & ~clr & (&bin);

   always_ff @(posedge clk) begin
      if (rst) begin
         bin  <= '0;
         gray <= '0;
         wrap <= 1'b0;
      end else begin
         bin  <= bin_next;
         gray <= gray_next;
         wrap <= wrap_next;
      end
   end

   gray_matches_bin_a : assert property (@(posedge clk) disable iff (rst)
      gray == ((bin >> 1) ^ bin));

   gray_single_step_a : assert property (@(posedge clk) disable iff (rst)
      (!$past(rst) && !$past(clr)) |-> ($countones(gray ^ $past(gray)) <= 1));

   wrap_at_zero_a : assert property (@(posedge clk) disable iff (rst)
      wrap |-> (bin == '0));

endmodule

// File: tb/tb_bin2gray_ptr.sv
// Scoreboard bench for bin2gray_ptr at SIZE 4, 3 and 6 driven with shared stimulus.
// A modular-counter model supplies expected values; a monitor pops and compares each cycle.
module tb_bin2gray_ptr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inc = 1'b0;
   logic clr = 1'b0;

   logic [3:0] b4, g4, bn4, gn4;
   logic [2:0] b3, g3, bn3, gn3;
   logic [5:0] b6, g6, bn6, gn6;
   logic       w4, w3, w6;

   always #5 clk = ~clk;

   bin2gray_ptr #(.SIZE(4)) u_dut4 (
      .clk(clk), .rst(rst), .inc(inc), .clr(clr),
      .bin(b4), .gray(g4), .bin_next(bn4), .gray_next(gn4), .wrap(w4));

   bin2gray_ptr #(.SIZE(3)) u_dut3 (
      .clk(clk), .rst(rst), .inc(inc), .clr(clr),
      .bin(b3), .gray(g3), .bin_next(bn3), .gray_next(gn3), .wrap(w3));

   bin2gray_ptr #(.SIZE(6)) u_dut6 (
      .clk(clk), .rst(rst), .inc(inc), .clr(clr),
      .bin(b6), .gray(g6), .bin_next(bn6), .gray_next(gn6), .wrap(w6));

   typedef struct {
      bit chk_comb;
      bit chk_step;
      int nxt[3];
      int bin[3];
      bit wrap[3];
   } exp_t;

   exp_t q[$];

   int  total = 0;
   int  bad   = 0;
   int  widths[3] = '{4, 3, 6};
   int  mods[3]   = '{16, 8, 64};
   int  cnt[3]    = '{0, 0, 0};
   int  model_wraps[3] = '{0, 0, 0};
   int  dut_wraps[3]   = '{0, 0, 0};
   bit  model_valid = 1'b0;

   int act_bin[3], act_gray[3], act_bn[3], act_gn[3];
   bit act_wrap[3];

   assign act_bin[0] = 32'(b4);
   assign act_bin[1] = 32'(b3);
   assign act_bin[2] = 32'(b6);
   assign act_gray[0] = 32'(g4);
   assign act_gray[1] = 32'(g3);
   assign act_gray[2] = 32'(g6);
   assign act_bn[0] = 32'(bn4);
   assign act_bn[1] = 32'(bn3);
   assign act_bn[2] = 32'(bn6);
   assign act_gn[0] = 32'(gn4);
   assign act_gn[1] = 32'(gn3);
   assign act_gn[2] = 32'(gn6);
   assign act_wrap[0] = w4;
   assign act_wrap[1] = w3;
   assign act_wrap[2] = w6;

   function automatic int to_gray(input int x);
      return x ^ (x >> 1);
   endfunction

   // Reference decoder: each binary bit is the XOR of all Gray bits at or above it.
   function automatic int from_gray(input int g, input int w);
      int b = 0;
      int acc = 0;
      for (int i = w - 1; i >= 0; i--) begin
         acc = acc ^ ((g >> i) & 1);
         b = b | (acc << i);
      end
      return b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit c, input bit i);
      exp_t e;
      @(negedge clk);
      rst = r;
      clr = c;
      inc = i;
      e.chk_comb = model_valid;
      e.chk_step = model_valid && !r && !c;
      for (int k = 0; k < 3; k++) begin
         int nx;
         bit w;
         nx = c ? 0 : (i ? (cnt[k] + 1) % mods[k] : cnt[k]);
         w  = !r && !c && i && (cnt[k] == mods[k] - 1);
         e.nxt[k]  = nx;
         e.wrap[k] = w;
         cnt[k]    = r ? 0 : nx;
         e.bin[k]  = cnt[k];
         if (w) model_wraps[k]++;
      end
      if (r) model_valid = 1'b1;
      q.push_back(e);
   endtask

   task automatic goto(input int target);
      step(1'b0, 1'b1, 1'b0);
      for (int n = 0; n < target; n++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      int   prev_gray[3];
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
               if (e.chk_comb) begin
                  check($sformatf("bin_next%0d", widths[k]), act_bn[k], e.nxt[k]);
                  check($sformatf("gray_next%0d", widths[k]), act_gn[k], to_gray(e.nxt[k]));
               end
               prev_gray[k] = act_gray[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
               check($sformatf("bin%0d", widths[k]), act_bin[k], e.bin[k]);
               check($sformatf("gray%0d", widths[k]), act_gray[k], to_gray(e.bin[k]));
               check($sformatf("wrap%0d", widths[k]), 32'(act_wrap[k]), 32'(e.wrap[k]));
               check($sformatf("gray2bin%0d", widths[k]),
                     from_gray(act_gray[k], widths[k]), e.bin[k]);
               if (e.chk_step)
                  check($sformatf("gray_onebit%0d", widths[k]),
                        32'($countones(act_gray[k] ^ prev_gray[k]) <= 1), 1);
               if (act_wrap[k]) dut_wraps[k]++;
            end
         end
      end
   end

   initial begin : driver
      // Reset held with inc asserted, then first count.
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      // Full sweep through rollover, then idle.
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 16; n++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      // Hold pattern from 0101.
      goto(5);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      // clr with inc at all-ones, then clr alone at all-ones.
      goto(15);
      step(1'b0, 1'b1, 1'b1);
      goto(15);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      // Rollover immediately followed by reset.
      goto(15);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      // Random inc/clr with rare resets.
      for (int n = 0; n < 10000; n++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 80);
      step(1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      for (int k = 0; k < 3; k++)
         check($sformatf("wrap_count%0d", widths[k]), dut_wraps[k], model_wraps[k]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
